// File: rtl/drbe_tap_scheduler.sv
// Tap scheduler: captures a (delay, obj_id) table from the config stream, then sweeps a sample
// counter and emits a one-cycle tap pulse for each enabled entry whose delay equals the sample index.
module drbe_tap_scheduler #(
  parameter int delay_length = 14,
  parameter int obj_id_width = 2,
  parameter int N_obj        = 4
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    cfg_clear,
  input  logic                    cfg_valid,
  input  logic [delay_length-1:0] delay_matrix_element,
  input  logic [obj_id_width-1:0] obj_id_element,
  input  logic                    run_en,
  output logic                    cfg_ready,
  output logic                    armed,
  output logic [delay_length-1:0] sample_cnt,
  output logic                    out_valid,
  output logic [obj_id_width-1:0] out_obj_id,
  output logic [delay_length-1:0] out_delay,
  output logic                    done,
  output logic                    collision_err
);

  localparam int PTR_W = (N_obj > 1) ? $clog2(N_obj) : 1;
  localparam int CNT_W = $clog2(N_obj + 1);
  localparam logic [delay_length-1:0] DISABLED    = '1;
  localparam logic [delay_length-1:0] LAST_SAMPLE = {{(delay_length-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {S_LOAD, S_ARMED, S_RUN, S_DONE} state_t;

  state_t state, state_next;

  logic [delay_length-1:0] tbl_delay [N_obj];
  logic [obj_id_width-1:0] tbl_id    [N_obj];
  logic [PTR_W-1:0]        wr_ptr;
  logic [CNT_W-1:0]        enabled_cnt, emit_cnt;

  logic [N_obj-1:0]        match;
  logic [CNT_W-1:0]        match_cnt, en_cnt;
  logic [PTR_W-1:0]        hit_idx;
  logic                    hit;

  // Parallel compare of the sample index against every table entry.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    match     = '0;
    match_cnt = '0;
    en_cnt    = '0;
    hit_idx   = '0;
    hit       = 1'b0;
    for (int i = 0; i < N_obj; i++) begin
      if (tbl_delay[i] != DISABLED) begin
        en_cnt = en_cnt + CNT_W'(1);
        if (tbl_delay[i] == sample_cnt) match[i] = 1'b1;
      end
      match_cnt = match_cnt + CNT_W'(match[i]);
    end
    // Scan downward so the lowest matching index is the one left standing.
    for (int i = N_obj - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_LOAD:  if (cfg_valid && wr_ptr == PTR_W'(N_obj - 1)) state_next = S_ARMED;
      S_ARMED: if (run_en) state_next = S_RUN;
      S_RUN: begin
        if (!run_en)                                                  state_next = S_ARMED;
        else if (emit_cnt == enabled_cnt || sample_cnt == LAST_SAMPLE) state_next = S_DONE;
      end
      S_DONE:  if (!run_en) state_next = S_ARMED;
      default: state_next = S_LOAD;
    endcase
    if (cfg_clear) state_next = S_LOAD;
  end

  always_ff @(posedge CLK or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) state <= S_LOAD;
    else       state <= state_next;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      // NOTE: the table is only N_obj entries and its disabled default is observable, so it is reset like any register.
      for (int i = 0; i < N_obj; i++) begin
        tbl_delay[i] <= DISABLED;
        tbl_id[i]    <= '0;
      end
      wr_ptr        <= '0;
      enabled_cnt   <= '0;
      emit_cnt      <= '0;
      sample_cnt    <= '0;
      out_valid     <= 1'b0;
      out_obj_id    <= '0;
      out_delay     <= '0;
      collision_err <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (cfg_clear) begin
        for (int i = 0; i < N_obj; i++) begin
          tbl_delay[i] <= DISABLED;
          tbl_id[i]    <= '0;
        end
        wr_ptr        <= '0;
        enabled_cnt   <= '0;
        emit_cnt      <= '0;
        sample_cnt    <= '0;
        collision_err <= 1'b0;
      end else begin
        case (state)
          S_LOAD: if (cfg_valid) begin
            tbl_delay[wr_ptr] <= delay_matrix_element;
            tbl_id[wr_ptr]    <= obj_id_element;
            wr_ptr <= (wr_ptr == PTR_W'(N_obj - 1)) ? '0 : wr_ptr + PTR_W'(1);
          end
          S_ARMED: if (run_en) begin
            sample_cnt  <= '0;
            emit_cnt    <= '0;
            enabled_cnt <= en_cnt;
          end
          S_RUN: begin
            if (!run_en) begin
              sample_cnt <= '0;
            end else begin
              if (hit) begin
                out_valid  <= 1'b1;
                out_obj_id <= tbl_id[hit_idx];
                out_delay  <= sample_cnt;
              end
              // Dropped collision losers still count, so the run ends once every enabled entry is accounted for.
              emit_cnt <= emit_cnt + match_cnt;
              if (match_cnt > CNT_W'(1)) collision_err <= 1'b1;
              if (sample_cnt != LAST_SAMPLE) sample_cnt <= sample_cnt + delay_length'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign cfg_ready = (state == S_LOAD);
  assign armed     = (state == S_ARMED);
  assign done      = (state == S_DONE);

endmodule

// File: tb/tb_drbe_tap_scheduler.sv
// Directed bench for drbe_tap_scheduler: expected pulses are queued by the stimulus and
// popped by an independent monitor whenever out_valid is seen.
module tb_drbe_tap_scheduler;

  localparam int DL = 14;
  localparam int IW = 2;
  localparam logic [DL-1:0] OFF = 14'h3fff;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DL-1:0] d;
  } pulse_t;

  logic          CLK = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_clear = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [DL-1:0] delay_matrix_element = '0;
  logic [IW-1:0] obj_id_element = '0;
  logic          run_en = 1'b0;
  logic          cfg_ready, armed, out_valid, done, collision_err;
  logic [DL-1:0] sample_cnt, out_delay;
  logic [IW-1:0] out_obj_id;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_pulse_cyc = -1;
  pulse_t sb_q[$];

  drbe_tap_scheduler #(.delay_length(DL), .obj_id_width(IW), .N_obj(4)) dut (
    .CLK(CLK), .reset(reset), .cfg_clear(cfg_clear), .cfg_valid(cfg_valid),
    .delay_matrix_element(delay_matrix_element), .obj_id_element(obj_id_element),
    .run_en(run_en), .cfg_ready(cfg_ready), .armed(armed), .sample_cnt(sample_cnt),
    .out_valid(out_valid), .out_obj_id(out_obj_id), .out_delay(out_delay),
    .done(done), .collision_err(collision_err)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every observed pulse must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (!reset && out_valid === 1'b1) begin
      last_pulse_cyc = cyc;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got id=%0d delay=%0d expected none (t=%0t)",
                 out_obj_id, out_delay, $time);
      end else begin
        pulse_t e;
        e = sb_q.pop_front();
        check("pulse_id", 32'(out_obj_id), 32'(e.id));
        check("pulse_delay", 32'(out_delay), 32'(e.d));
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; run_en = 1'b0; cfg_valid = 1'b0; cfg_clear = 1'b0;
    repeat (2) @(posedge CLK);
    #1 reset = 1'b0;
  endtask

  task automatic beat(input logic [DL-1:0] d, input logic [IW-1:0] id);
    cfg_valid = 1'b1; delay_matrix_element = d; obj_id_element = id;
    @(posedge CLK);
    #1 cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (done === 1'b1) begin
        dcyc = cyc;
        break;
      end
    end
    if (dcyc < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: done not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_sample(input string name, input logic [DL-1:0] k);
    bit seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (sample_cnt == k) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: sample_cnt never reached %0d", name, k);
    end
  endtask

  initial begin
    int dcyc;

    // Reset state.
    do_reset();
    @(negedge CLK);
    check("rst_cfg_ready", 32'(cfg_ready), 1);
    check("rst_armed", 32'(armed), 0);
    check("rst_done", 32'(done), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_collision", 32'(collision_err), 0);
    check("rst_sample_cnt", 32'(sample_cnt), 0);

    // Two enabled entries far apart; done one cycle after the last pulse.
    beat(14'd10000, 2'd0); beat(14'd10010, 2'd1); beat(OFF, 2'd2); beat(OFF, 2'd3);
    @(negedge CLK);
    check("t1_armed", 32'(armed), 1);
    check("t1_cfg_ready", 32'(cfg_ready), 0);
    sb_q.push_back('{id: 2'd0, d: 14'd10000});
    sb_q.push_back('{id: 2'd1, d: 14'd10010});
    run_en = 1'b1;
    wait_done("t1_done", 10100, dcyc);
    check("t1_done_after_pulse", 32'(dcyc - last_pulse_cyc), 1);
    check("t1_no_collision", 32'(collision_err), 0);
    check("t1_queue_empty", 32'(sb_q.size()), 0);

    // Collision at 5: id0 wins, id1 dropped, sticky error.
    do_reset();
    beat(14'd5, 2'd0); beat(14'd5, 2'd1); beat(14'd9, 2'd2); beat(OFF, 2'd3);
    sb_q.push_back('{id: 2'd0, d: 14'd5});
    sb_q.push_back('{id: 2'd2, d: 14'd9});
    run_en = 1'b1;
    wait_done("t2_done", 50, dcyc);
    check("t2_done_after_pulse", 32'(dcyc - last_pulse_cyc), 1);
    check("t2_collision", 32'(collision_err), 1);
    check("t2_queue_empty", 32'(sb_q.size()), 0);
    // Drop run_en from S_DONE, rerun the retained table.
    run_en = 1'b0;
    @(negedge CLK);
    check("t2_rearmed", 32'(armed), 1);
    check("t2_done_low", 32'(done), 0);
    sb_q.push_back('{id: 2'd0, d: 14'd5});
    sb_q.push_back('{id: 2'd2, d: 14'd9});
    run_en = 1'b1;
    wait_done("t2_rerun_done", 50, dcyc);
    check("t2_rerun_queue_empty", 32'(sb_q.size()), 0);
    check("t2_collision_sticky", 32'(collision_err), 1);

    // cfg_clear drops everything; all-disabled table finishes almost at once.
    run_en = 1'b0;
    cfg_clear = 1'b1;
    @(posedge CLK);
    #1 cfg_clear = 1'b0;
    @(negedge CLK);
    check("t3_clear_cfg_ready", 32'(cfg_ready), 1);
    check("t3_clear_collision", 32'(collision_err), 0);
    beat(OFF, 2'd0); beat(OFF, 2'd1); beat(OFF, 2'd2); beat(OFF, 2'd3);
    run_en = 1'b1;
    wait_done("t3_done_fast", 3, dcyc);
    check("t3_queue_empty", 32'(sb_q.size()), 0);

    // Six beats: the last two land in S_ARMED and are ignored.
    do_reset();
    beat(14'd2, 2'd3); beat(14'd4, 2'd2); beat(14'd6, 2'd1); beat(14'd8, 2'd0);
    beat(14'd1, 2'd1); beat(14'd3, 2'd2);
    @(negedge CLK);
    check("t4_armed", 32'(armed), 1);
    sb_q.push_back('{id: 2'd3, d: 14'd2});
    sb_q.push_back('{id: 2'd2, d: 14'd4});
    sb_q.push_back('{id: 2'd1, d: 14'd6});
    sb_q.push_back('{id: 2'd0, d: 14'd8});
    run_en = 1'b1;
    wait_done("t4_done", 50, dcyc);
    check("t4_queue_empty", 32'(sb_q.size()), 0);

    // Async reset while the matching sample is being compared.
    do_reset();
    beat(14'd7, 2'd1); beat(OFF, 2'd0); beat(OFF, 2'd2); beat(OFF, 2'd3);
    run_en = 1'b1;
    wait_sample("t5_reach7", 14'd7);
    reset = 1'b1;
    run_en = 1'b0;
    #1;
    check("t5_rst_out_valid", 32'(out_valid), 0);
    check("t5_rst_cfg_ready", 32'(cfg_ready), 1);
    check("t5_rst_sample_cnt", 32'(sample_cnt), 0);
    repeat (2) @(posedge CLK);
    #1 reset = 1'b0;
    repeat (4) @(negedge CLK);
    check("t5_still_load", 32'(cfg_ready), 1);
    check("t5_queue_empty", 32'(sb_q.size()), 0);

    // Abort at sample 3, re-raise: counter restarts and a single pulse at 4.
    do_reset();
    beat(14'd4, 2'd3); beat(OFF, 2'd0); beat(OFF, 2'd1); beat(OFF, 2'd2);
    sb_q.push_back('{id: 2'd3, d: 14'd4});
    run_en = 1'b1;
    wait_sample("t6_reach3", 14'd3);
    run_en = 1'b0;
    @(negedge CLK);
    check("t6_abort_armed", 32'(armed), 1);
    check("t6_abort_sample", 32'(sample_cnt), 0);
    check("t6_no_early_pulse", 32'(sb_q.size()), 1);
    run_en = 1'b1;
    wait_done("t6_done", 50, dcyc);
    check("t6_queue_empty", 32'(sb_q.size()), 0);

    run_en = 1'b0;
    repeat (3) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
